uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, frame buffer depth in entries (power of two, 2..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cfg  input  config_t  fields: br_div (16-bit, clk cycles per bit), word (0=8 data bits, 1=9 data bits), stop (0=1 stop bit, 1=2 stop bits), en (1=frames may start).
REQ-005 wr_data  input  9  frame payload; bit 8 is used only when word=1.
REQ-006 wr_en  input  1  one-cycle push strobe; the block writes wr_data into the FIFO when not full.
REQ-007 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-008 level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-009 ovf  output  1  sticky; set by a push while full.
REQ-010 tx_out  output  1  serial line, registered, idle high.
REQ-011 idle  output  1  high when the FSM is in IDLE and the FIFO is empty.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY (only with the macro defined), and STOP.
REQ-013 IDLE->START SHALL occur on the edge where FIFO is non-empty and cfg.en=1; that edge pops the head entry and latches cfg.br_div, cfg.word and cfg.stop for the whole frame.
REQ-014 A push to an empty FIFO while in IDLE with en=1 SHALL drive tx_out low on the next rising edge after the write edge (1-cycle latency).
REQ-015 Each bit SHALL be held exactly br_div cycles; a latched br_div of 0 SHALL be treated as 1.
REQ-016 Data SHALL be sent LSB first: 8 bits (word=0) or 9 bits (word=1).
REQ-017 STOP SHALL drive tx_out high for 1 or 2 bit periods per the latched stop value.
REQ-018 At the end of STOP, with FIFO non-empty and en=1, START SHALL begin on the next cycle with no idle gap; otherwise the FSM SHALL return to IDLE.
REQ-019 A push with full=1 and no same-edge pop SHALL be dropped and SHALL set ovf; a push and a pop on the same edge while full SHALL be accepted, with level unchanged.
REQ-020 The read/write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH.
REQ-021 Deasserting en mid-frame SHALL NOT abort the frame; it only blocks the next START.
REQ-022 Changes to cfg mid-frame SHALL have no effect until the next START.

Reset
REQ-023 rst=1 SHALL immediately force: FSM=IDLE, tx_out=1, FIFO empty, level=0, full=0, ovf=0, idle=1, all counters 0.
REQ-024 Reset during a frame SHALL abandon the frame and discard all FIFO contents; the line SHALL return high asynchronously.
REQ-025 After release, the first START SHALL require a new push.

Configuration
REQ-026 Macro UART_TX_PARITY_EN: when defined, a PARITY bit period carrying even parity over the transmitted data bits SHALL be inserted between DATA and STOP.
REQ-027 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP.

Verification
REQ-028 br_div=8, word=0, stop=0, push 'h8e -> tx_out 0,0,1,1,1,0,0,0,1,1, each bit 8 cycles (80 cycles total), then idle=1.
REQ-029 word=1, stop=1, push 'h1fe -> start bit, data 0,1,1,1,1,1,1,1,1, then 2 stop bits; 96 cycles total at br_div=8.
REQ-030 Push 'h81 and 'h55 on consecutive cycles -> two frames back-to-back, second start bit on the cycle after the first stop bit ends, level 2->1->0.
REQ-031 FIFO_DEPTH=8, en=0, 9 pushes -> full=1, level=8, ovf=1, 9th entry dropped; set en=1 -> 8 frames in push order.
REQ-032 Assert rst mid-DATA -> tx_out=1 in the same cycle, level=0, and no further frames after release.
REQ-033 With UART_TX_PARITY_EN defined, push 'h07, word=0 -> parity bit 1 (three ones) before the stop bit; frame length 11 bit periods.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo -- UART transmitter fed by a frame FIFO.
//
// Frames are pushed into a FIFO and serialised as: one start bit (low), 8 or 9
// data bits LSB first, an optional even-parity bit, then 1 or 2 stop bits
// (high). The frame format and bit period are captured at the moment a frame
// starts, so cfg may change freely mid-frame. Back-to-back frames follow with
// no idle gap while the FIFO has data and cfg.en is set.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s). Without the macro the parity
// state and its logic are not built.
//
// Parameters:
//   FIFO_DEPTH  frame buffer depth in entries (power of two, 2..64)
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   cfg      in   config_t {br_div, word, stop, en}
//   wr_data  in   9-bit frame payload (bit 8 used only for 9-bit words)
//   wr_en    in   one-cycle push strobe
//   full     out  FIFO holds FIFO_DEPTH entries
//   level    out  FIFO occupancy
//   ovf      out  sticky, set by a push that was dropped because full
//   tx_out   out  serial line, registered, idle high
//   idle     out  FSM in IDLE and FIFO empty
// -----------------------------------------------------------------------------

package uart_tx_fifo_pkg;
    typedef struct packed {
        logic [15:0] br_div;
        logic        word;
        logic        stop;
        logic        en;
    } config_t;
endpackage

module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  config_t                       cfg,
    input  logic [8:0]                    wr_data,
    input  logic                          wr_en,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf,
    output logic                          tx_out,
    output logic                          idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);
    localparam logic [LVL_W-1:0] ZERO_L  = LVL_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity over the data bits actually transmitted for this word size.
    function automatic logic even_parity(input logic [8:0] data, input logic word9);
        logic [8:0] mask_v;
        begin
            mask_v = word9 ? 9'h1ff : 9'h0ff;
            return ^(data & mask_v);
        end
    endfunction
`endif

    // FIFO storage and status
    logic [8:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] count_r;
    logic             full_r;
    logic             ovf_r;
    logic             idle_r;

    // Transmitter state, all latched per frame at START
    state_t           state_r;
    logic [15:0]      cnt_r;
    logic [15:0]      div_r;
    logic             word_r;
    logic             stop_left_r;
    logic [3:0]       bit_idx_r;
    logic [8:0]       shift_r;
    logic             tx_r;
`ifdef UART_TX_PARITY_EN
    logic             par_r;
`endif

    // Combinational handshake between FSM and FIFO
    logic             bit_end_s;
    logic             can_start_s;
    logic             stop_done_s;
    logic             pop_s;
    logic             push_s;
    logic             ovf_set_s;
    logic [LVL_W-1:0] count_nxt_s;
    logic             idle_nxt_s;
    logic [8:0]       head_s;
    logic [15:0]      div_eff_s;

    // Pop/push decisions, next occupancy and next idle flag.
    always_comb begin
        bit_end_s   = (cnt_r == (div_r - 16'd1));
        can_start_s = (count_r != ZERO_L) && cfg.en;
        stop_done_s = 1'b0;
        pop_s       = 1'b0;
        head_s      = mem_r[rd_ptr_r];
        // A bit period of zero cycles is meaningless; run it as one cycle.
        if (cfg.br_div == 16'd0) begin
            div_eff_s = 16'd1;
        end else begin
            div_eff_s = cfg.br_div;
        end
        case (state_r)
            ST_IDLE: begin
                pop_s = can_start_s;
            end
            ST_STOP: begin
                stop_done_s = bit_end_s && !stop_left_r;
                pop_s       = stop_done_s && can_start_s;
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
        // When full, a push is still accepted if the same edge pops a slot free.
        push_s    = wr_en && (!full_r || pop_s);
        ovf_set_s = wr_en && full_r && !pop_s;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + ONE_L;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - ONE_L;
        end else begin
            count_nxt_s = count_r;
        end
        idle_nxt_s = ((state_r == ST_IDLE) || stop_done_s) && !pop_s
                     && (count_nxt_s == ZERO_L);
    end

    // FIFO payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy, full/overflow and idle status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_L;
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
            idle_r   <= 1'b1;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_L);
            ovf_r   <= ovf_r || ovf_set_s;
            idle_r  <= idle_nxt_s;
        end
    end

    // Transmit FSM: bit timing, shifting and the registered serial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            div_r       <= 16'd0;
            word_r      <= 1'b0;
            stop_left_r <= 1'b0;
            bit_idx_r   <= 4'd0;
            shift_r     <= 9'd0;
            tx_r        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 16'd0;
                    if (pop_s) begin
                        state_r     <= ST_START;
                        div_r       <= div_eff_s;
                        word_r      <= cfg.word;
                        stop_left_r <= cfg.stop;
                        shift_r     <= head_s;
`ifdef UART_TX_PARITY_EN
                        par_r       <= even_parity(head_s, cfg.word);
`endif
                        tx_r        <= 1'b0;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r   <= ST_DATA;
                        cnt_r     <= 16'd0;
                        bit_idx_r <= 4'd0;
                        tx_r      <= shift_r[0];
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= 16'd0;
                        if (bit_idx_r == (word_r ? 4'd8 : 4'd7)) begin
`ifdef UART_TX_PARITY_EN
                            state_r <= ST_PARITY;
                            tx_r    <= par_r;
`else
                            state_r <= ST_STOP;
                            tx_r    <= 1'b1;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                            shift_r   <= shift_r >> 1;
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        state_r <= ST_STOP;
                        cnt_r   <= 16'd0;
                        tx_r    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        cnt_r <= 16'd0;
                        if (stop_left_r) begin
                            // Second stop bit requested for this frame.
                            stop_left_r <= 1'b0;
                        end else if (pop_s) begin
                            // Next frame starts immediately, no idle gap.
                            state_r     <= ST_START;
                            div_r       <= div_eff_s;
                            word_r      <= cfg.word;
                            stop_left_r <= cfg.stop;
                            shift_r     <= head_s;
`ifdef UART_TX_PARITY_EN
                            par_r       <= even_parity(head_s, cfg.word);
`endif
                            tx_r        <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 16'd0;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign full   = full_r;
    assign level  = count_r;
    assign ovf    = ovf_r;
    assign tx_out = tx_r;
    assign idle   = idle_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo -- directed self-checking bench for uart_tx_fifo.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Frame bit patterns are listed in transmit order, bit 0 = first bit on line.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    logic        clk;
    logic        rst;
    config_t     cfg;
    logic [8:0]  wr_data;
    logic        wr_en;
    logic        full;
    logic [3:0]  level;
    logic        ovf;
    logic        tx_out;
    logic        idle;

    int checks;
    int failures;

    uart_tx_fifo #(.FIFO_DEPTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg     (cfg),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .full    (full),
        .level   (level),
        .ovf     (ovf),
        .tx_out  (tx_out),
        .idle    (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [15:0] div, input logic word, input logic stop, input logic en);
        cfg.br_div = div;
        cfg.word   = word;
        cfg.stop   = stop;
        cfg.en     = en;
    endtask

    // Call just after the edge that entered START; returns just after the
    // edge that ends the last bit of the frame.
    task automatic run_frame(input string tag, input logic [11:0] bits, input int nbits, input int div);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < div; c++) begin
                chk(tag, {31'd0, tx_out}, {31'd0, bits[i]});
                step(1);
            end
        end
    endtask

    task automatic push(input logic [8:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        step(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 9'd0;
        set_cfg(16'd8, 1'b0, 1'b0, 1'b1);

        // Reset state
        #1;
        chk("rst_tx", {31'd0, tx_out}, 32'd1);
        chk("rst_level", {28'd0, level}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        step(2);
        rst = 1'b0;
        step(2);
        chk("post_rst_tx", {31'd0, tx_out}, 32'd1);

        // 8N1 frame of 'h8e, one-cycle start latency
        push(9'h08e);
        chk("lat_tx_hi", {31'd0, tx_out}, 32'd1);
        chk("lat_level", {28'd0, level}, 32'd1);
        step(1);
        chk("lat_level0", {28'd0, level}, 32'd0);
        run_frame("f8e", 12'b0011_0001_1100, 10, 8);
        chk("f8e_idle", {31'd0, idle}, 32'd1);
        chk("f8e_tx", {31'd0, tx_out}, 32'd1);

        // 9-bit, 2 stop bits, 'h1fe; cfg scrambled right after START
        set_cfg(16'd8, 1'b1, 1'b1, 1'b1);
        push(9'h1fe);
        step(1);
        set_cfg(16'd3, 1'b0, 1'b0, 1'b0);
        run_frame("f1fe", 12'b1111_1111_1100, 12, 8);
        chk("f1fe_idle", {31'd0, idle}, 32'd1);

        // Two queued frames go out back to back
        set_cfg(16'd8, 1'b0, 1'b0, 1'b0);
        push(9'h081);
        push(9'h055);
        chk("b2b_level2", {28'd0, level}, 32'd2);
        chk("b2b_idle0", {31'd0, idle}, 32'd0);
        chk("b2b_hold_tx", {31'd0, tx_out}, 32'd1);
        cfg.en = 1'b1;
        step(1);
        chk("b2b_level1", {28'd0, level}, 32'd1);
        run_frame("f81", 12'b0011_0000_0010, 10, 8);
        chk("b2b_level0", {28'd0, level}, 32'd0);
        run_frame("f55", 12'b0010_1010_1010, 10, 8);
        chk("b2b_idle", {31'd0, idle}, 32'd1);

        // Overflow: 9 pushes with en=0, then push+pop on the same edge while full
        set_cfg(16'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            push(9'h010 + 9'(i));
            if (i == 7) begin
                chk("ovf_full8", {31'd0, full}, 32'd1);
                chk("ovf_not_yet", {31'd0, ovf}, 32'd0);
            end
        end
        chk("ovf_level", {28'd0, level}, 32'd8);
        chk("ovf_full", {31'd0, full}, 32'd1);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        cfg.en  = 1'b1;
        wr_data = 9'h099;
        wr_en   = 1'b1;
        step(1);
        wr_en   = 1'b0;
        chk("pp_level", {28'd0, level}, 32'd8);
        chk("pp_full", {31'd0, full}, 32'd1);
        for (int k = 0; k < 9; k++) begin
            d = (k == 8) ? 8'h99 : (8'h10 + 8'(k));
            run_frame("ovf_frame", {2'b11, 1'b1, d, 1'b0}, 10, 2);
        end
        chk("ovf_drain_idle", {31'd0, idle}, 32'd1);
        chk("ovf_drain_level", {28'd0, level}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);

        // br_div of zero runs as one cycle per bit
        set_cfg(16'd0, 1'b0, 1'b0, 1'b1);
        push(9'h08e);
        step(1);
        run_frame("div0", 12'b0011_0001_1100, 10, 1);
        chk("div0_idle", {31'd0, idle}, 32'd1);

        // Optional parity bit on 'h07
        set_cfg(16'd2, 1'b0, 1'b0, 1'b1);
        push(9'h007);
        step(1);
`ifdef UART_TX_PARITY_EN
        run_frame("f07_par", 12'b0110_0000_1110, 11, 2);
`else
        run_frame("f07", 12'b0010_0000_1110, 10, 2);
`endif
        chk("f07_idle", {31'd0, idle}, 32'd1);

        // Reset in the middle of DATA
        set_cfg(16'd8, 1'b0, 1'b0, 1'b1);
        wr_data = 9'h000;
        wr_en   = 1'b1;
        step(2);
        wr_en   = 1'b0;
        step(11);
        chk("mid_data_tx", {31'd0, tx_out}, 32'd0);
        chk("mid_data_level", {28'd0, level}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tx", {31'd0, tx_out}, 32'd1);
        chk("arst_level", {28'd0, level}, 32'd0);
        chk("arst_ovf", {31'd0, ovf}, 32'd0);
        chk("arst_idle", {31'd0, idle}, 32'd1);
        step(1);
        rst = 1'b0;
        step(40);
        chk("after_rst_tx", {31'd0, tx_out}, 32'd1);
        chk("after_rst_idle", {31'd0, idle}, 32'd1);
        chk("after_rst_level", {28'd0, level}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
